// File: rtl/vc_buffer_pkg.sv
// vc_buffer_pkg: shared helpers for the virtual-channel input buffer.
//   clog2      - constant ceiling log2, used to size pointers and counts
//   vc_count_t - wide container for a channel occupancy count, used for
//                threshold compares that are independent of the counter width
//   vc_base    - first storage address of a channel (v * depth)
package vc_buffer_pkg;

  localparam int CNT_W_MAX = 16;

  typedef logic [CNT_W_MAX-1:0] vc_count_t;

  function automatic int clog2(input int value);
    int r;
    r = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 32'sd1;
      end
    end
    return r;
  endfunction

  function automatic int vc_base(input int v, input int depth);
    return v * depth;
  endfunction

endpackage

// File: rtl/vc_fifo_ctrl.sv
// vc_fifo_ctrl: pointer/count/flag state for one virtual channel.
// The caller presents only accepted operations, so wr_en never arrives
// while full and rd_en never arrives while empty.
//   clk, rst     - clock, synchronous active-high reset
//   wr_en, rd_en - accepted write / accepted pop this cycle
//   head, tail   - slot of the oldest entry / next free slot
//   count        - occupancy 0..vc_depth
//   full, empty, almost_full - registered flags matching count
module vc_fifo_ctrl
  import vc_buffer_pkg::*;
#(
  parameter int vc_depth     = 8,
  parameter int afull_thresh = 6,
  parameter int pw           = 3,
  parameter int cw           = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic [pw-1:0] head,
  output logic [pw-1:0] tail,
  output logic [cw-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full
);

  logic [pw-1:0] r_head, r_tail;
  logic [cw-1:0] r_count;
  logic          r_full, r_empty, r_afull;
  logic [pw-1:0] w_head_nxt, w_tail_nxt;
  logic [cw-1:0] w_count_nxt;

  // Next pointers (wrap at vc_depth-1, which need not be a power of two) and count.
  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    if (rd_en) begin
      if (r_head == pw'(vc_depth - 1)) begin
        w_head_nxt = {pw{1'b0}};
      end else begin
        w_head_nxt = r_head + {{(pw-1){1'b0}}, 1'b1};
      end
    end else begin
      w_head_nxt = r_head;
    end
    if (wr_en) begin
      if (r_tail == pw'(vc_depth - 1)) begin
        w_tail_nxt = {pw{1'b0}};
      end else begin
        w_tail_nxt = r_tail + {{(pw-1){1'b0}}, 1'b1};
      end
    end else begin
      w_tail_nxt = r_tail;
    end
    case ({wr_en, rd_en})
      2'b10:   w_count_nxt = r_count + {{(cw-1){1'b0}}, 1'b1};
      2'b01:   w_count_nxt = r_count - {{(cw-1){1'b0}}, 1'b1};
      default: w_count_nxt = r_count;
    endcase
  end

  // State registers; flags are derived from the next count so they stay in step with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= {pw{1'b0}};
      r_tail  <= {pw{1'b0}};
      r_count <= {cw{1'b0}};
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_afull <= 1'b0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == cw'(vc_depth));
      r_empty <= (w_count_nxt == {cw{1'b0}});
      r_afull <= (vc_count_t'(w_count_nxt) >= vc_count_t'(afull_thresh));
    end
  end

  assign head        = r_head;
  assign tail        = r_tail;
  assign count       = r_count;
  assign full        = r_full;
  assign empty       = r_empty;
  assign almost_full = r_afull;

endmodule

// File: rtl/vc_buffer.sv
// vc_buffer: one storage array split into num_vc independent show-ahead FIFOs.
//   clk, rst        - clock, synchronous active-high reset
//   in, in_vc       - write data and target channel, qualified by produce
//   consume, rd_vc  - pop request; rd_vc also selects which head drives out
//   out             - head of rd_vc, 0 when that channel is empty
//   full/empty/almost_full - per-channel flags; usedw - per-channel counts
//   overflow/underflow     - sticky error flags, cleared only by rst
module vc_buffer
  import vc_buffer_pkg::*;
#(
  parameter int  num_vc       = 4,
  parameter int  vc_depth     = 8,
  parameter int  buffer_width = 64,
  parameter int  afull_thresh = 6,
  localparam int vcw = (clog2(num_vc) < 1) ? 1 : clog2(num_vc),
  localparam int pw  = (clog2(vc_depth) < 1) ? 1 : clog2(vc_depth),
  localparam int cw  = clog2(vc_depth + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [buffer_width-1:0] in,
  input  logic [vcw-1:0]          in_vc,
  input  logic                    produce,
  input  logic                    consume,
  input  logic [vcw-1:0]          rd_vc,
  output logic [buffer_width-1:0] out,
  output logic [num_vc-1:0]       full,
  output logic [num_vc-1:0]       empty,
  output logic [num_vc-1:0]       almost_full,
  output logic [num_vc*cw-1:0]    usedw,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int depth_total = num_vc * vc_depth;
  localparam int aw          = (clog2(depth_total) < 1) ? 1 : clog2(depth_total);

  logic [buffer_width-1:0] r_mem [depth_total];
  logic                    r_overflow, r_underflow;

  logic [pw-1:0]           w_head  [num_vc];
  logic [pw-1:0]           w_tail  [num_vc];
  logic [cw-1:0]           w_count [num_vc];
  logic [num_vc-1:0]       w_full, w_empty, w_afull;
  logic [num_vc-1:0]       w_wr_en, w_rd_en;
  logic [aw-1:0]           w_wr_addr, w_rd_addr;
  logic                    w_wr_bad, w_rd_bad, w_rd_has;
  logic                    w_in_ok, w_rd_ok;
  logic [buffer_width-1:0] w_out;

  // Channel tags beyond num_vc are only possible when num_vc is not a power of two.
  assign w_in_ok = (int'(in_vc) < num_vc);
  assign w_rd_ok = (int'(rd_vc) < num_vc);

  // Write/pop decode against registered flags; a full channel drops the write even if popped now.
  always_comb begin
    w_wr_en   = {num_vc{1'b0}};
    w_rd_en   = {num_vc{1'b0}};
    w_wr_addr = {aw{1'b0}};
    w_rd_addr = {aw{1'b0}};
    w_wr_bad  = 1'b0;
    w_rd_bad  = 1'b0;
    w_rd_has  = 1'b0;
    if (w_in_ok) begin
      w_wr_addr = aw'(vc_base(int'(in_vc), vc_depth) + int'(w_tail[in_vc]));
      if (produce && !w_full[in_vc]) begin
        w_wr_en[in_vc] = 1'b1;
      end else begin
        w_wr_bad = produce;
      end
    end else begin
      w_wr_bad = produce;
    end
    if (w_rd_ok) begin
      w_rd_addr = aw'(vc_base(int'(rd_vc), vc_depth) + int'(w_head[rd_vc]));
      w_rd_has  = !w_empty[rd_vc];
      if (consume && !w_empty[rd_vc]) begin
        w_rd_en[rd_vc] = 1'b1;
      end else begin
        w_rd_bad = consume;
      end
    end else begin
      w_rd_bad = consume;
    end
  end

  genvar v;
  generate
    for (v = 0; v < num_vc; v++) begin : g_vc
      vc_fifo_ctrl #(
        .vc_depth    (vc_depth),
        .afull_thresh(afull_thresh),
        .pw          (pw),
        .cw          (cw)
      ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (w_wr_en[v]),
        .rd_en      (w_rd_en[v]),
        .head       (w_head[v]),
        .tail       (w_tail[v]),
        .count      (w_count[v]),
        .full       (w_full[v]),
        .empty      (w_empty[v]),
        .almost_full(w_afull[v])
      );
      assign usedw[v*cw +: cw] = w_count[v];
    end
  endgenerate

  // Shared storage, single write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (|w_wr_en) begin
      r_mem[w_wr_addr] <= in;
    end
  end

  // Show-ahead read, zero-gated so an empty channel never exposes stale data.
  always_comb begin
    w_out = {buffer_width{1'b0}};
    if (w_rd_has) begin
      w_out = r_mem[w_rd_addr];
    end else begin
      w_out = {buffer_width{1'b0}};
    end
  end

  // Sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= r_overflow | w_wr_bad;
      r_underflow <= r_underflow | w_rd_bad;
    end
  end

  assign out         = w_out;
  assign full        = w_full;
  assign empty       = w_empty;
  assign almost_full = w_afull;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule
